dpram_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the two ports of the team's single-clock true dual-port RAM (32-bit data, 16-bit address, 1-cycle registered read) among NREQ requesters. Each cycle it grants up to two requests, one per RAM port, and drives the RAM port signals directly. One cycle later it routes RAM read data back to the requester that issued the read. It also resolves same-address port conflicts, which the RAM itself does not handle.

---
 rtl/dpram_rr_arbiter_if.sv | 25 ++
 rtl/dpram_rr_arbiter.sv | 118 +++++++++++
 tb/tb_dpram_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_rr_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: per-requester request,
// access attributes, grant and read-return signals packed by requester index.
interface dpram_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [NREQ*DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the two
// ports of a true dual-port RAM, with same-address conflict resolution.
module dpram_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  dpram_rr_arbiter_if.slave   bus,
  output logic                ram_we_a,
  output logic                ram_we_b,
  output logic [AW-1:0]       ram_addr_a,
  output logic [AW-1:0]       ram_addr_b,
  output logic [DW-1:0]       ram_data_a,
  output logic [DW-1:0]       ram_data_b,
  input  logic [DW-1:0]       ram_q_a,
  input  logic [DW-1:0]       ram_q_b
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PW-1:0] idx_t;

  idx_t          ptr;
  idx_t          a_idx, b_idx, last_idx;
  logic          a_found, b_found, conflict, a_gnt, b_gnt;
  logic [AW-1:0] addr_a, addr_b;

  logic          tag_v_a, tag_rd_a, tag_v_b, tag_rd_b;
  idx_t          tag_id_a, tag_id_b;

  // Cyclic successor of base by k positions; base and k are both below NREQ.
  function automatic idx_t wrap(input int base, input int k);
    int s;
    s = base + k;
    if (s >= NREQ) s = s - NREQ;
    return idx_t'(s);
  endfunction

  // Two cascaded priority scans: A from ptr, B from A+1 excluding A.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    a_found = 1'b0;
    a_idx   = '0;
    b_found = 1'b0;
    b_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!a_found && bus.req[wrap(int'(ptr), k)]) begin
        a_found = 1'b1;
        a_idx   = wrap(int'(ptr), k);
      end
    end
    for (int k = 1; k < NREQ; k++) begin
      if (a_found && !b_found && bus.req[wrap(int'(a_idx), k)]) begin
        b_found = 1'b1;
        b_idx   = wrap(int'(a_idx), k);
      end
    end
  end

  assign addr_a   = bus.addr[int'(a_idx)*AW +: AW];
  assign addr_b   = bus.addr[int'(b_idx)*AW +: AW];
  assign conflict = b_found && (addr_a == addr_b) && (bus.we[a_idx] || bus.we[b_idx]);

  // NOTE: grants are gated by rst_n combinationally, so reset idles the RAM ports in the same cycle.
  assign a_gnt    = rst_n && a_found;
  assign b_gnt    = rst_n && b_found && !conflict;
  assign last_idx = b_gnt ? b_idx : a_idx;

  always_comb begin
    bus.gnt = '0;
    if (a_gnt) bus.gnt[a_idx] = 1'b1;
    if (b_gnt) bus.gnt[b_idx] = 1'b1;
  end

  assign ram_we_a   = a_gnt && bus.we[a_idx];
  assign ram_addr_a = a_gnt ? addr_a : '0;
  assign ram_data_a = a_gnt ? bus.wdata[int'(a_idx)*DW +: DW] : '0;
  assign ram_we_b   = b_gnt && bus.we[b_idx];
  assign ram_addr_b = b_gnt ? addr_b : '0;
  assign ram_data_b = b_gnt ? bus.wdata[int'(b_idx)*DW +: DW] : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      tag_v_a  <= 1'b0;
      tag_rd_a <= 1'b0;
      tag_id_a <= '0;
      tag_v_b  <= 1'b0;
      tag_rd_b <= 1'b0;
      tag_id_b <= '0;
    end else begin
      if (a_gnt) ptr <= wrap(int'(last_idx), 1);
      tag_v_a  <= a_gnt;
      tag_rd_a <= !bus.we[a_idx];
      tag_id_a <= a_idx;
      tag_v_b  <= b_gnt;
      tag_rd_b <= !bus.we[b_idx];
      tag_id_b <= b_idx;
    end
  end

  // Ports A and B never hold the same requester, so the two returns never overlap.
  always_comb begin
    bus.rvalid = '0;
    bus.rdata  = '0;
    if (rst_n && tag_v_a && tag_rd_a) begin
      bus.rvalid[tag_id_a]                 = 1'b1;
      bus.rdata[int'(tag_id_a)*DW +: DW]   = ram_q_a;
    end
    if (rst_n && tag_v_b && tag_rd_b) begin
      bus.rvalid[tag_id_b]                 = 1'b1;
      bus.rdata[int'(tag_id_b)*DW +: DW]   = ram_q_b;
    end
  end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Bench for dpram_rr_arbiter: behavioural RAM, rotation-list reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_dpram_rr_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int CW   = NREQ*DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dpram_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  logic          ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_data_a, ram_data_b;
  logic [DW-1:0] ram_q_a, ram_q_b;

  dpram_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_we_a   (ram_we_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_data_a (ram_data_a),
    .ram_data_b (ram_data_b),
    .ram_q_a    (ram_q_a),
    .ram_q_b    (ram_q_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  function automatic logic [AW-1:0] aslice(input logic [NREQ*AW-1:0] v, input int i);
    return v[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] dslice(input logic [CW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Single-clock true dual-port RAM with one-cycle registered read.
  logic [DW-1:0] mem    [0:65535];
  logic [DW-1:0] shadow [0:65535];
  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a]    = init_val(AW'(a));
      shadow[a] = init_val(AW'(a));
    end
  end

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
  end

  // Reference model: requesters listed in rotation order from ptr; the first
  // two get ports A and B unless the second clashes on address with a write.
  int               m_ptr = 0;
  logic [NREQ-1:0]  m_rv  = '0;
  logic [CW-1:0]    m_rd  = '0;

  always @(negedge clk) begin : model
    int              order[$];
    int              ga, gb, idx;
    logic [NREQ-1:0] e_gnt, n_rv;
    logic [CW-1:0]   n_rd;
    logic [48:0]     e_pa, e_pb;

    order = {};
    if (rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (bus.req[idx]) order.push_back(idx);
      end
    end
    ga = (order.size() > 0) ? order[0] : -1;
    gb = (order.size() > 1) ? order[1] : -1;
    if (gb >= 0 && aslice(bus.addr, ga) == aslice(bus.addr, gb) && (bus.we[ga] || bus.we[gb]))
      gb = -1;

    e_gnt = '0;
    e_pa  = '0;
    e_pb  = '0;
    if (ga >= 0) begin
      e_gnt[ga] = 1'b1;
      e_pa = {bus.we[ga], aslice(bus.addr, ga), dslice(bus.wdata, ga)};
    end
    if (gb >= 0) begin
      e_gnt[gb] = 1'b1;
      e_pb = {bus.we[gb], aslice(bus.addr, gb), dslice(bus.wdata, gb)};
    end

    check("mdl_gnt",    CW'(bus.gnt), CW'(e_gnt));
    check("mdl_port_a", CW'({ram_we_a, ram_addr_a, ram_data_a}), CW'(e_pa));
    check("mdl_port_b", CW'({ram_we_b, ram_addr_b, ram_data_b}), CW'(e_pb));
    check("mdl_rvalid", CW'(bus.rvalid), rst_n ? CW'(m_rv) : '0);
    check("mdl_rdata",  bus.rdata, rst_n ? m_rd : '0);

    n_rv = '0;
    n_rd = '0;
    foreach (order[j]) begin
      idx = order[j];
      if ((idx == ga || idx == gb) && !bus.we[idx]) begin
        n_rv[idx]            = 1'b1;
        n_rd[idx*DW +: DW]   = shadow[aslice(bus.addr, idx)];
      end
    end
    if (ga >= 0 && bus.we[ga]) shadow[aslice(bus.addr, ga)] = dslice(bus.wdata, ga);
    if (gb >= 0 && bus.we[gb]) shadow[aslice(bus.addr, gb)] = dslice(bus.wdata, gb);
    if (!rst_n)       m_ptr = 0;
    else if (ga >= 0) m_ptr = (((gb >= 0) ? gb : ga) + 1) % NREQ;
    m_rv = n_rv;
    m_rd = n_rd;
  end

  // Stimulus: inputs change 1 time unit after the rising edge, literal checks 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic setr(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[i]                = w;
    bus.addr[i*AW +: AW]     = a;
    bus.wdata[i*DW +: DW]    = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset with everything idle, then release with no requests.
    tick(); tick(); settle();
    check("rst_gnt",    CW'(bus.gnt), '0);
    check("rst_rvalid", CW'(bus.rvalid), '0);
    check("rst_we",     CW'({ram_we_a, ram_we_b}), '0);
    tick(); rst_n = 1'b1; settle();
    tick(); settle();
    check("idle_gnt",   CW'(bus.gnt), '0);
    check("idle_port",  CW'({ram_addr_a, ram_data_a, ram_addr_b, ram_data_b}), '0);

    // Write then read of the same address by different requesters.
    tick(); bus.req = 4'b0001; setr(0, 1'b1, 16'h0010, 32'hDEADBEEF); settle();
    check("wr_gnt",     CW'(bus.gnt), CW'(4'b0001));
    check("wr_port_a",  CW'({ram_we_a, ram_addr_a, ram_data_a}), CW'({1'b1, 16'h0010, 32'hDEADBEEF}));
    check("wr_we_b",    CW'(ram_we_b), '0);
    tick(); bus.req = 4'b0010; setr(1, 1'b0, 16'h0010, 32'h0); settle();
    check("rd_gnt",     CW'(bus.gnt), CW'(4'b0010));
    tick(); bus.req = 4'b0000; settle();
    check("rd_rvalid",  CW'(bus.rvalid), CW'(4'b0010));
    check("rd_rdata",   CW'(dslice(bus.rdata, 1)), CW'(32'hDEADBEEF));

    // Single read by requester 3 rotates the pointer back to 0.
    tick(); bus.req = 4'b1000; setr(3, 1'b0, 16'h0030, 32'h0); settle();
    check("r3_gnt",     CW'(bus.gnt), CW'(4'b1000));

    // All four read distinct addresses continuously.
    tick(); bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) setr(i, 1'b0, AW'(16'h0020 + i), 32'h0);
    settle();
    check("rr0_gnt",    CW'(bus.gnt), CW'(4'b0011));
    check("rr0_rvalid", CW'(bus.rvalid), CW'(4'b1000));
    tick(); settle();
    check("rr1_gnt",    CW'(bus.gnt), CW'(4'b1100));
    check("rr1_rvalid", CW'(bus.rvalid), CW'(4'b0011));
    check("rr1_rd0",    CW'(dslice(bus.rdata, 0)), CW'(32'hFFDF0020));
    check("rr1_rd1",    CW'(dslice(bus.rdata, 1)), CW'(32'hFFDE0021));
    tick(); settle();
    check("rr2_gnt",    CW'(bus.gnt), CW'(4'b0011));
    check("rr2_rvalid", CW'(bus.rvalid), CW'(4'b1100));
    check("rr2_rd3",    CW'(dslice(bus.rdata, 3)), CW'(32'hFFDC0023));
    tick(); settle();
    check("rr3_gnt",    CW'(bus.gnt), CW'(4'b1100));
    tick(); bus.req = 4'b0000; settle();
    check("rr4_rvalid", CW'(bus.rvalid), CW'(4'b1100));

    // Two writes to one address: B is held off a cycle, last write wins.
    tick(); bus.req = 4'b0101;
    setr(0, 1'b1, 16'h0100, 32'h11111111);
    setr(2, 1'b1, 16'h0100, 32'h22222222);
    settle();
    check("cf_gnt",     CW'(bus.gnt), CW'(4'b0001));
    check("cf_we_b",    CW'(ram_we_b), '0);
    tick(); bus.req = 4'b0100; settle();
    check("cf2_gnt",    CW'(bus.gnt), CW'(4'b0100));
    check("cf2_data",   CW'(ram_data_a), CW'(32'h22222222));
    tick(); bus.req = 4'b0010; setr(1, 1'b0, 16'h0100, 32'h0); settle();
    check("cf3_gnt",    CW'(bus.gnt), CW'(4'b0010));
    tick(); bus.req = 4'b0000; settle();
    check("cf3_rdata",  CW'({bus.rvalid, dslice(bus.rdata, 1)}), CW'({4'b0010, 32'h22222222}));

    // Two reads of one address are both granted.
    tick(); bus.req = 4'b1010;
    setr(1, 1'b0, 16'h0005, 32'h0);
    setr(3, 1'b0, 16'h0005, 32'h0);
    settle();
    check("rr_same_gnt",  CW'(bus.gnt), CW'(4'b1010));
    check("rr_same_addr", CW'({ram_addr_a, ram_addr_b}), CW'({16'h0005, 16'h0005}));
    tick(); bus.req = 4'b0000; settle();
    check("rr_same_rv",   CW'(bus.rvalid), CW'(4'b1010));
    check("rr_same_rd",   CW'({dslice(bus.rdata, 1), dslice(bus.rdata, 3)}), CW'({32'hFFFA0005, 32'hFFFA0005}));

    // Reset right after a read grant drops the response and resets the pointer.
    tick(); bus.req = 4'b0001; setr(0, 1'b0, 16'h0010, 32'h0); settle();
    check("mr_gnt",     CW'(bus.gnt), CW'(4'b0001));
    tick(); bus.req = 4'b0000; rst_n = 1'b0; settle();
    check("mr_rv_rst",  CW'(bus.rvalid), '0);
    tick(); rst_n = 1'b1; settle();
    check("mr_rv_post", CW'({bus.rvalid, bus.rdata}), '0);
    tick(); bus.req = 4'b1111;
    setr(0, 1'b0, 16'h0010, 32'h0);
    setr(1, 1'b0, 16'h0100, 32'h0);
    setr(2, 1'b0, 16'h0020, 32'h0);
    setr(3, 1'b0, 16'h0021, 32'h0);
    settle();
    check("mr_ptr0",    CW'(bus.gnt), CW'(4'b0011));
    tick(); bus.req = 4'b0000; settle();
    check("mr_rdback",  CW'({bus.rvalid, dslice(bus.rdata, 0), dslice(bus.rdata, 1)}),
          CW'({4'b0011, 32'hDEADBEEF, 32'h22222222}));

    // Mixed traffic on a tiny address set to stress conflicts and rotation.
    for (int c = 0; c < 60; c++) begin
      tick();
      bus.req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        setr(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom);
    end
    tick(); bus.req = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
